// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared encodings for the execute unit
package exec_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_MULHU = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_REM   = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_BLT = 2'b10;
    localparam logic [1:0] BR_BGE = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/md_iter.sv
// rtl/md_iter.sv - iterative shift-add multiplier and restoring divider
module md_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] STEPS = CW'(XLEN);

    // acc_q holds {product_hi, product_lo} for multiply, {remainder, quotient} for divide
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [3:0]        op_q;
    logic              qneg_q;
    logic              rneg_q;
    logic              bzero_q;
    logic              active_q;
    logic [CW-1:0]     cnt_q;

    logic              signed_op;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     trial;
    logic              ge;
    logic [XLEN-1:0]   new_rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // Operand conditioning at start and one multiply or divide step per cycle
    always_comb begin
        signed_op = (op == OP_DIV) || (op == OP_REM);
        a_mag     = (signed_op && a[XLEN-1]) ? -a : a;
        b_mag     = (signed_op && b[XLEN-1]) ? -b : b;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        trial     = acc_q[2*XLEN-1:XLEN-1];
        ge        = trial >= {1'b0, opnd_q};
        new_rem   = ge ? XLEN'(trial - {1'b0, opnd_q}) : trial[XLEN-1:0];
    end

    // Load on start, then iterate until XLEN steps have been taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start) begin
            op_q     <= op;
            acc_q    <= is_div_op(op) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b};
            opnd_q   <= is_div_op(op) ? b_mag : a;
            qneg_q   <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
            rneg_q   <= signed_op && a[XLEN-1];
            bzero_q  <= (b == '0);
            active_q <= 1'b1;
            cnt_q    <= '0;
        end else if (active_q && (cnt_q != STEPS)) begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div_op(op_q)) begin
                acc_q <= {new_rem, acc_q[XLEN-2:0], ge};
            end else begin
                acc_q <= {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    // Final selection and sign correction; a zero divisor already leaves rem = |a|
    always_comb begin
        quo    = acc_q[XLEN-1:0];
        rem    = acc_q[2*XLEN-1:XLEN];
        result = '0;
        case (op_q)
            OP_MUL:   result = quo;
            OP_MULHU: result = rem;
            OP_DIVU:  result = quo;
            OP_REMU:  result = rem;
            OP_DIV:   result = bzero_q ? '1 : (qneg_q ? -quo : quo);
            OP_REM:   result = rneg_q ? -rem : rem;
            default:  result = '0;
        endcase
    end

    assign done = active_q && (cnt_q == STEPS);

endmodule

// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - multi-cycle execute unit with ALU, branch compare and M-ops
module execute_mc
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int HAS_MD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            branch,
    input  logic [1:0]      br_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] CNT_LAST = SW'(XLEN - 1);

    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            taken_q, taken_d;
    logic            pend_taken_q, pend_taken_d;

    logic            accept;
    logic            use_md;
    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic [XLEN-1:0] alu_res;
    logic [SW-1:0]   shamt;
    logic            br_cond;
    logic            br_hit;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign use_md   = (HAS_MD != 0) && (is_mul_op(op) || is_div_op(op));
    assign shamt    = b[SW-1:0];

    // Single-cycle ALU; without the M-unit, M-ops fall back to ADD
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD: alu_res = a + b;
            OP_SUB: alu_res = a - b;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SRA: alu_res = XLEN'($signed(a) >>> shamt);
            OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (HAS_MD == 0) begin
                    alu_res = a + b;
                end
            end
            default: alu_res = '0;
        endcase
    end

    // Branch condition on the request operands, regardless of op
    always_comb begin
        br_cond = 1'b0;
        case (br_type)
            BR_BEQ: br_cond = (a == b);
            BR_BNE: br_cond = (a != b);
            BR_BLT: br_cond = ($signed(a) <  $signed(b));
            BR_BGE: br_cond = ($signed(a) >= $signed(b));
            default: br_cond = 1'b0;
        endcase
        br_hit = branch && br_cond;
    end

    generate
        if (HAS_MD != 0) begin : g_md
            md_iter #(.XLEN(XLEN)) u_md_iter (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (md_start),
                .op     (op),
                .a      (a),
                .b      (b),
                .done   (md_done),
                .result (md_result)
            );
        end else begin : g_no_md
            assign md_done   = 1'b0;
            assign md_result = '0;
        end
    endgenerate

    // Control FSM: a consumed output frees the slot in the same cycle a new one is loaded
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        taken_d      = taken_q;
        pend_taken_d = pend_taken_q;
        md_start     = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (use_md) begin
                        md_start     = 1'b1;
                        cnt_d        = '0;
                        pend_taken_d = br_hit;
                        state_d      = is_mul_op(op) ? ST_MUL : ST_DIV;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        taken_d     = br_hit;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (md_done) begin
                    out_valid_d = 1'b1;
                    result_d    = md_result;
                    taken_d     = pend_taken_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            taken_q      <= 1'b0;
            pend_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            taken_q      <= taken_d;
            pend_taken_q <= pend_taken_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign branch_taken = taken_q;
    assign busy         = (state_q == ST_MUL) || (state_q == ST_DIV);

endmodule
